router_fsm: RTL and testbench

- Packet-level controller for the 1x3 router.
- Sequences header decode, payload load, FIFO-full stall, parity load and parity check.
- Drives the state strobes consumed by the router register block (header/parity latching, internal parity reset) and the write_enb_reg / detect_add inputs of the router synchronizer.
- Sits between the 8-bit input port and the three output FIFOs. It tracks the destination port's empty and soft_reset status for the packet in flight.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fsm.sv | 122 ++++++++++++
 tb/tb_router_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router: FSM state encoding,
// address width and the reserved destination address.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router: header decode, payload load,
// FIFO-full stall, parity load/check, with a latched destination address.
module router_fsm
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              sel_empty, sel_soft, hdr_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      // The reserved address is dropped, so it never replaces a valid latch.
      if (state == DECODE_ADDRESS && pkt_valid && data_in != INVALID_ADDR)
        addr_q <= data_in;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    sel_empty = 1'b0;
    sel_soft  = 1'b0;
    hdr_empty = 1'b0;
    case (addr_q)
      2'd0:    begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
      2'd1:    begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
      2'd2:    begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
      default: begin sel_empty = 1'b0;         sel_soft = 1'b0;         end
    endcase
    // Header decode looks at the live address so there is no latch latency.
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = DECODE_ADDRESS;
    if (state != DECODE_ADDRESS && sel_soft) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != INVALID_ADDR)
            state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          else
            state_nxt = DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: state_nxt = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
          else                 state_nxt = LOAD_DATA;
        end
        FIFO_FULL_STATE: state_nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state)
      DECODE_ADDRESS:     begin detect_add = 1'b1; busy = 1'b0; end
      LOAD_FIRST_DATA:    lfd_state = 1'b1;
      LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b0; end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      FIFO_FULL_STATE:    full_state = 1'b1;
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb_reg = 1'b1; end
      WAIT_TILL_EMPTY:    ;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default:            begin detect_add = 1'b1; busy = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; the state is identified from
// its Moore output signature after each rising edge.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int compared   = 0;
  int mismatched = 0;

  // Signature order: detect_add lfd ld laf full rst_int write_enb busy
  localparam logic [7:0] S_DA   = 8'b1000_0000;
  localparam logic [7:0] S_LFD  = 8'b0100_0001;
  localparam logic [7:0] S_LD   = 8'b0010_0010;
  localparam logic [7:0] S_LAF  = 8'b0001_0011;
  localparam logic [7:0] S_FULL = 8'b0000_1001;
  localparam logic [7:0] S_CPE  = 8'b0000_0101;
  localparam logic [7:0] S_WTE  = 8'b0000_0001;
  localparam logic [7:0] S_LP   = 8'b0000_0011;

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sig();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bring a fresh packet for port 1 into LOAD_DATA.
  task automatic enter_ld(input string tag);
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); check({tag, "_lfd"}, sig(), S_LFD);
    step(); check({tag, "_ld"},  sig(), S_LD);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // 1. Reset and idle
    #12;
    check("reset", sig(), S_DA);
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); check("idle", sig(), S_DA);
    end

    // 2. Normal packet to port 1, four payload cycles
    enter_ld("pkt1");
    for (int i = 0; i < 3; i++) begin
      step(); check("pkt1_ld_hold", sig(), S_LD);
    end
    pkt_valid = 1'b0;
    step(); check("pkt1_lp",  sig(), S_LP);
    step(); check("pkt1_cpe", sig(), S_CPE);
    step(); check("pkt1_da",  sig(), S_DA);

    // 3a. Full stall, then low_pkt_valid -> LOAD_PARITY
    enter_ld("full1");
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check("full1_full", sig(), S_FULL);
    end
    fifo_full = 1'b0;
    step(); check("full1_laf", sig(), S_LAF);
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step(); check("full1_lp", sig(), S_LP);
    low_pkt_valid = 1'b0;
    // CHECK_PARITY_ERROR with fifo_full goes back to the stall state
    step(); check("full1_cpe", sig(), S_CPE);
    fifo_full = 1'b1;
    step(); check("cpe_to_full", sig(), S_FULL);
    fifo_full = 1'b0;
    step(); check("cpe_full_laf", sig(), S_LAF);
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step(); check("laf_pd_prio", sig(), S_DA);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // 3b. LOAD_AFTER_FULL with neither flag resumes loading; fifo_full beats ~pkt_valid
    enter_ld("full2");
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step(); check("ld_full_prio", sig(), S_FULL);
    fifo_full = 1'b0; pkt_valid = 1'b1;
    step(); check("full2_laf", sig(), S_LAF);
    step(); check("laf_to_ld", sig(), S_LD);
    fifo_full = 1'b1;
    step(); check("full3_full", sig(), S_FULL);
    fifo_full = 1'b0;
    step(); check("full3_laf", sig(), S_LAF);
    parity_done = 1'b1; pkt_valid = 1'b0;
    step(); check("laf_pd_da", sig(), S_DA);
    parity_done = 1'b0;

    // Soft reset of the addressed port aborts LOAD_DATA
    enter_ld("soft1");
    soft_reset_1 = 1'b1;
    step(); check("soft_ld_abort", sig(), S_DA);
    soft_reset_1 = 1'b0; pkt_valid = 1'b0;

    // 4. Wait for port 2 to drain
    fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
    step(); check("wte_enter", sig(), S_WTE);
    for (int i = 0; i < 10; i++) begin
      step(); check("wte_hold", sig(), S_WTE);
    end
    fifo_empty_2 = 1'b1;
    step(); check("wte_lfd", sig(), S_LFD);
    step(); check("wte_ld",  sig(), S_LD);
    pkt_valid = 1'b0;
    step(); check("wte_lp",  sig(), S_LP);
    step(); check("wte_cpe", sig(), S_CPE);
    step(); check("wte_da",  sig(), S_DA);

    // 5. Reserved address is dropped and does not disturb the latch
    pkt_valid = 1'b1; data_in = 2'd3;
    step(); check("addr3_stay", sig(), S_DA);
    step(); check("addr3_stay2", sig(), S_DA);
    check("addr3_latch", {6'b0, dut.addr_q}, 8'd2);
    fifo_empty_0 = 1'b0; data_in = 2'd0;
    step(); check("wte0_enter", sig(), S_WTE);
    pkt_valid = 1'b0;
    soft_reset_1 = 1'b1;
    step(); check("wte0_other_soft", sig(), S_WTE);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step(); check("wte0_soft", sig(), S_DA);
    soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
    step(); check("soft_idle", sig(), S_DA);

    // 6. Asynchronous reset mid-LOAD_DATA
    enter_ld("async");
    @(negedge clk); resetn = 1'b0;
    #1;
    check("async_reset", sig(), S_DA);
    check("async_latch", {6'b0, dut.addr_q}, 8'd0);
    pkt_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    step(); check("post_reset", sig(), S_DA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
